// File: rtl/hash_sequencer.sv
// Sequences a SHA-256 core through a double hash of an 80-byte header per nonce,
// compares the digest against a leading-zero target and walks the nonce range.
module hash_sequencer #(
    parameter int SEL_MAX   = 64,
    parameter int ZBITS     = 32,
    parameter int NONCE_IDX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] nonce_start,
    input  logic [31:0] nonce_end,
    output logic [4:0]  hdr_addr,
    input  logic [31:0] hdr_data,
    output logic [1:0]  block,
    output logic [6:0]  select,
    output logic [31:0] msg_in,
    input  logic [31:0] h1,
    input  logic [31:0] h2,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [31:0] nonce_out,
    output logic [63:0] hash_hi
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BLK0  = 3'd1;
    localparam logic [2:0] S_BLK1  = 3'd2;
    localparam logic [2:0] S_BLK2  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [6:0] SEL_LAST = 7'(SEL_MAX);
    localparam logic [6:0] SEL_NIDX = 7'(NONCE_IDX);

    logic [2:0]  state;
    logic [2:0]  nstate;
    logic [6:0]  nsel;
    logic [31:0] nonce;
    logic [31:0] nonce_last;
    logic [63:0] digest;
    logic        hit;

    function automatic logic is_hit(input logic [63:0] d);
        logic [63:0] mask;
        mask = ~64'd0 << (64 - ZBITS);
        return (d & mask) == 64'd0;
    endfunction

    function automatic logic [1:0] blk_code(input logic [2:0] st);
        case (st)
            S_BLK0:  return 2'd0;
            S_BLK1:  return 2'd1;
            S_BLK2:  return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Word presented to the core in the cycle where state/select equal st/s.
    function automatic logic [31:0] msg_word(input logic [2:0] st, input logic [6:0] s,
                                             input logic [31:0] hd, input logic [31:0] nc);
        logic [31:0] w;
        w = 32'd0;
        if (s < 7'd16) begin
            if (st == S_BLK0) begin
                w = hd;
            end else if (st == S_BLK1) begin
                if (s < 7'd3)          w = hd;
                else if (s == SEL_NIDX) w = nc;
                else if (s == 7'd4)     w = 32'h8000_0000;
                else if (s == 7'd15)    w = 32'h0000_0280;
            end
        end
        return w;
    endfunction

    // hdr_addr runs one cycle ahead so the registered msg_in lines up with select.
    function automatic logic [4:0] next_addr(input logic [2:0] st, input logic [6:0] s,
                                             input logic [4:0] cur);
        logic [4:0] a;
        a = cur;
        case (st)
            S_IDLE, S_CHECK, S_DONE: a = 5'd0;
            S_BLK0: begin
                if (s < 7'd15)            a = 5'(s + 7'd1);
                else if (s == SEL_LAST)   a = 5'd16;
            end
            S_BLK1: begin
                if (s < 7'd2)             a = 5'(s + 7'd17);
            end
            default: a = cur;
        endcase
        return a;
    endfunction

    assign digest = {h1, h2};
    assign hit    = is_hit(digest);

    always_comb begin
        nstate = state;
        nsel   = 7'd0;
        case (state)
            S_IDLE:  if (start) nstate = S_BLK0;
            S_BLK0:  if (select == SEL_LAST) nstate = S_BLK1; else nsel = select + 7'd1;
            S_BLK1:  if (select == SEL_LAST) nstate = S_BLK2; else nsel = select + 7'd1;
            S_BLK2:  if (select == SEL_LAST) nstate = S_CHECK; else nsel = select + 7'd1;
            S_CHECK: nstate = (hit || nonce == nonce_last) ? S_DONE : S_BLK0;
            S_DONE:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
        if (abort) begin
            nstate = S_IDLE;
            nsel   = 7'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            block      <= 2'd3;
            select     <= 7'd0;
            msg_in     <= 32'd0;
            hdr_addr   <= 5'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            nonce_out  <= 32'd0;
            hash_hi    <= 64'd0;
            nonce      <= 32'd0;
            nonce_last <= 32'd0;
        end else begin
            state    <= nstate;
            select   <= nsel;
            block    <= blk_code(nstate);
            msg_in   <= msg_word(nstate, nsel, hdr_data, nonce);
            hdr_addr <= next_addr(nstate, nsel, hdr_addr);
            done     <= (nstate == S_DONE);
            busy     <= (nstate == S_BLK0) || (nstate == S_BLK1) ||
                        (nstate == S_BLK2) || (nstate == S_CHECK);
            if (!abort) begin
                if (state == S_IDLE && start) begin
                    nonce      <= nonce_start;
                    nonce_last <= nonce_end;
                    found      <= 1'b0;
                    nonce_out  <= 32'd0;
                end
                if (state == S_CHECK) begin
                    hash_hi <= digest;
                    if (hit) begin
                        found     <= 1'b1;
                        nonce_out <= nonce;
                    end else if (nonce == nonce_last) begin
                        found     <= 1'b0;
                        nonce_out <= nonce_last;
                    end else begin
                        nonce <= nonce + 32'd1;
                    end
                end
            end
        end
    end

endmodule
